// File: rtl/tile_search_if.sv
// Tile-chain bundle: search token handshake, clue inputs, row-bias request port and peer mask.
// master = chain/environment side, slave = tile_search cell.
interface tile_search_if #(
  parameter int unsigned ORDER = 2
);
  localparam int unsigned LEN = ORDER * ORDER;
  localparam int unsigned IW  = $clog2(LEN + 1);

  logic           myturn;
  logic           turndir;
  logic           givenvalid;
  logic [LEN-1:0] givenvalue;
  logic [IW-1:0]  rqindex;
  logic           rqvalid;
  logic [LEN-1:0] rowbias;
  logic [LEN-1:0] occupiedmask;
  logic [LEN-1:0] value;
  logic           passfwd;
  logic           passbak;
  logic           busy;

  modport master (
    output myturn, turndir, givenvalid, givenvalue, rowbias, occupiedmask,
    input  rqindex, rqvalid, value, passfwd, passbak, busy
  );

  modport slave (
    input  myturn, turndir, givenvalid, givenvalue, rowbias, occupiedmask,
    output rqindex, rqvalid, value, passfwd, passbak, busy
  );
endinterface

// File: rtl/tile_search.sv
// Brute-force search cell for one grid tile: walks the row-bias table, commits the first free
// candidate, resumes from the last tried entry on backtrack; clue tiles just echo their value.
module tile_search #(
  parameter int unsigned ORDER  = 2,
  parameter int unsigned RQ_LAT = 1
) (
  input logic          clock,
  input logic          reset,
  tile_search_if.slave bus
);
  localparam int unsigned LEN = ORDER * ORDER;
  localparam int unsigned IW  = $clog2(LEN + 1);

  typedef enum logic [2:0] {
    StIdle, StGiven, StIncr, StWait, StCheck, StPassFwd, StPassBak
  } state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  tried_q, tried_d;
  logic [IW-1:0]  rqindex_q, rqindex_d;
  logic           rqvalid_q, rqvalid_d;
  logic [LEN-1:0] value_q, value_d;
  logic           passfwd_q, passfwd_d;
  logic           passbak_q, passbak_d;
  logic           dir_q, dir_d;
  logic [2:0]     wcnt_q, wcnt_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= StIdle;
      tried_q   <= '0;
      rqindex_q <= '0;
      rqvalid_q <= 1'b0;
      value_q   <= '0;
      passfwd_q <= 1'b0;
      passbak_q <= 1'b0;
      dir_q     <= 1'b0;
      wcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      tried_q   <= tried_d;
      rqindex_q <= rqindex_d;
      rqvalid_q <= rqvalid_d;
      value_q   <= value_d;
      passfwd_q <= passfwd_d;
      passbak_q <= passbak_d;
      dir_q     <= dir_d;
      wcnt_q    <= wcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tried_d   = tried_q;
    rqindex_d = rqindex_q;
    rqvalid_d = 1'b0;
    value_d   = value_q;
    passfwd_d = 1'b0;
    passbak_d = 1'b0;
    dir_d     = dir_q;
    wcnt_d    = wcnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.myturn) begin
          dir_d = bus.turndir;
          if (bus.givenvalid) begin
            state_d = StGiven;
          end else begin
            state_d = StIncr;
            // Backtrack arrivals keep tried so the scan resumes past the last candidate.
            if (!bus.turndir) tried_d = '0;
          end
        end
      end
      StGiven: begin
        value_d = bus.givenvalue;
        state_d = dir_q ? StPassBak : StPassFwd;
      end
      StIncr: begin
        value_d = '0;
        if (tried_q == IW'(LEN)) begin
          tried_d = '0;
          state_d = StPassBak;
        end else begin
          rqindex_d = tried_q;
          rqvalid_d = 1'b1;
          tried_d   = tried_q + IW'(1);
          wcnt_d    = 3'(RQ_LAT - 1);
          state_d   = StWait;
        end
      end
      StWait: begin
        if (wcnt_q == 3'd0) state_d = StCheck;
        else                wcnt_d  = wcnt_q - 3'd1;
      end
      StCheck: begin
        if (bus.rowbias == '0 || (bus.rowbias & bus.occupiedmask) != '0) begin
          state_d = StIncr;
        end else begin
          value_d = bus.rowbias;
          state_d = StPassFwd;
        end
      end
      StPassFwd: begin
        passfwd_d = 1'b1;
        state_d   = StIdle;
      end
      StPassBak: begin
        passbak_d = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.rqindex = rqindex_q;
  assign bus.rqvalid = rqvalid_q;
  assign bus.value   = value_q;
  assign bus.passfwd = passfwd_q;
  assign bus.passbak = passbak_q;
  assign bus.busy    = (state_q != StIdle);
endmodule

// File: tb/tb_tile_search.sv
// Directed bench for tile_search: RQ_LAT=1 cell for the main scenarios, RQ_LAT=3 cell for latency.
module tb_tile_search;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  tile_search_if #(.ORDER(2)) b1 ();
  tile_search_if #(.ORDER(2)) b3 ();

  tile_search #(.ORDER(2), .RQ_LAT(1)) u_dut1 (.clock(clock), .reset(reset), .bus(b1.slave));
  tile_search #(.ORDER(2), .RQ_LAT(3)) u_dut3 (.clock(clock), .reset(reset), .bus(b3.slave));

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] tbl [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [2:0] rq_log1 [$];
  logic [2:0] rq_log3 [$];

  // Row-bias table responders: data valid for exactly one cycle, RQ_LAT cycles after the strobe.
  logic [2:0] v3 = '0;
  logic [2:0] i3_0 = '0;
  logic [2:0] i3_1 = '0;
  always @(posedge clock) begin
    b1.rowbias <= b1.rqvalid ? tbl[b1.rqindex[1:0]] : 4'b0000;
    v3   <= {v3[1:0], b3.rqvalid};
    i3_0 <= b3.rqindex;
    i3_1 <= i3_0;
    b3.rowbias <= v3[1] ? tbl[i3_1[1:0]] : 4'b0000;
    if (b1.rqvalid) rq_log1.push_back(b1.rqindex);
    if (b3.rqvalid) rq_log3.push_back(b3.rqindex);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic do_turn(input bit sel, input bit dir, output int lat, output bit fwd,
                         output bit bak, output logic [3:0] vmid, output logic [3:0] vend);
    bit f, b, bz;
    logic [3:0] v;
    rq_log1.delete();
    rq_log3.delete();
    if (sel) begin b3.myturn = 1'b1; b3.turndir = dir; end
    else     begin b1.myturn = 1'b1; b1.turndir = dir; end
    @(negedge clock);
    b1.myturn = 1'b0;
    b3.myturn = 1'b0;
    lat = 0; fwd = 0; bak = 0; vmid = '0; vend = '0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clock);
      f  = sel ? b3.passfwd : b1.passfwd;
      b  = sel ? b3.passbak : b1.passbak;
      v  = sel ? b3.value   : b1.value;
      bz = sel ? b3.busy    : b1.busy;
      if (n == 1) chk("busy_in_turn", 32'(bz), 32'd1);
      if (n == 2) vmid = v;
      if (f || b) begin
        lat = n; fwd = f; bak = b; vend = v;
        break;
      end
    end
    if (lat == 0) chk("turn_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_case(input string tag, input bit sel, input bit dir, input int elat,
                          input bit efwd, input logic [3:0] evmid, input logic [3:0] evend,
                          input int en, input logic [31:0] ecode);
    int lat;
    bit fwd, bak;
    logic [3:0] vmid, vend, occ;
    logic [31:0] code;
    do_turn(sel, dir, lat, fwd, bak, vmid, vend);
    occ = sel ? b3.occupiedmask : b1.occupiedmask;
    chk({tag, "_lat"},   32'(lat), 32'(elat));
    chk({tag, "_fwd"},   32'(fwd), 32'(efwd));
    chk({tag, "_bak"},   32'(bak), 32'(!efwd));
    chk({tag, "_vmid"},  32'(vmid), 32'(evmid));
    chk({tag, "_value"}, 32'(vend), 32'(evend));
    if (fwd) chk({tag, "_free"}, 32'(vend & occ), 32'd0);
    code = '0;
    if (sel) begin
      foreach (rq_log3[i]) code = {code[27:0], 1'b0, rq_log3[i]};
      chk({tag, "_rq_n"}, 32'(rq_log3.size()), 32'(en));
    end else begin
      foreach (rq_log1[i]) code = {code[27:0], 1'b0, rq_log1[i]};
      chk({tag, "_rq_n"}, 32'(rq_log1.size()), 32'(en));
    end
    chk({tag, "_rq_idx"}, code, ecode);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got running exp finished");
    $fatal(1);
  end

  initial begin
    b1.myturn = 0; b1.turndir = 0; b1.givenvalid = 0; b1.givenvalue = '0; b1.occupiedmask = '0;
    b3.myturn = 0; b3.turndir = 0; b3.givenvalid = 0; b3.givenvalue = '0; b3.occupiedmask = '0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_value",   32'(b1.value),   32'd0);
    chk("rst_rqindex", 32'(b1.rqindex), 32'd0);
    chk("rst_rqvalid", 32'(b1.rqvalid), 32'd0);
    chk("rst_passfwd", 32'(b1.passfwd), 32'd0);
    chk("rst_passbak", 32'(b1.passbak), 32'd0);
    chk("rst_busy",    32'(b1.busy),    32'd0);
    chk("rst_busy3",   32'(b3.busy),    32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Fresh turn, nothing occupied: first candidate taken.
    run_case("t1", 0, 0, 4, 1, 4'b0000, 4'b0001, 1, 32'h0);
    // Fresh turn, 0001/0010 occupied: two rejections.
    b1.occupiedmask = 4'b0011;
    run_case("t2", 0, 0, 10, 1, 4'b0000, 4'b0100, 3, 32'h012);
    // Backtrack resume: continues at entry 3, prior value released.
    b1.occupiedmask = 4'b0000;
    run_case("t3", 0, 1, 4, 1, 4'b0000, 4'b1000, 1, 32'h3);
    // Backtrack with table exhausted: pass back, no request.
    run_case("t4", 0, 1, 2, 0, 4'b0000, 4'b0000, 0, 32'h0);
    // Tried counter cleared by the pass back: restart at entry 0.
    run_case("t4b", 0, 1, 4, 1, 4'b0000, 4'b0001, 1, 32'h0);

    // Clue tile.
    b1.givenvalid = 1'b1;
    b1.givenvalue = 4'b0100;
    run_case("t5f", 0, 0, 2, 1, 4'b0100, 4'b0100, 0, 32'h0);
    run_case("t5b", 0, 1, 2, 0, 4'b0100, 4'b0100, 0, 32'h0);
    b1.givenvalid = 1'b0;

    // Reset in WAIT with a concurrent myturn.
    b1.myturn = 1'b1; b1.turndir = 1'b0;
    @(negedge clock);
    b1.myturn = 1'b0;
    @(negedge clock);
    chk("t6_rqvalid_pre", 32'(b1.rqvalid), 32'd1);
    reset = 1'b0;
    b1.myturn = 1'b1;
    @(negedge clock);
    chk("t6_value",   32'(b1.value),   32'd0);
    chk("t6_rqvalid", 32'(b1.rqvalid), 32'd0);
    chk("t6_rqindex", 32'(b1.rqindex), 32'd0);
    chk("t6_passfwd", 32'(b1.passfwd), 32'd0);
    chk("t6_passbak", 32'(b1.passbak), 32'd0);
    chk("t6_busy",    32'(b1.busy),    32'd0);
    reset = 1'b1;
    b1.myturn = 1'b0;
    repeat (3) @(negedge clock);
    chk("t6_idle_busy", 32'(b1.busy), 32'd0);
    chk("t6_idle_fwd",  32'(b1.passfwd), 32'd0);
    // Resume after reset starts from entry 0 since tried was cleared.
    run_case("t6r", 0, 1, 4, 1, 4'b0000, 4'b0001, 1, 32'h0);

    // Three-cycle row-bias latency, two rejections.
    b3.occupiedmask = 4'b0011;
    run_case("t7", 1, 0, 16, 1, 4'b0000, 4'b0100, 3, 32'h012);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
